rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- 8-way round-robin arbiter for one shared resource.
- Eight requesters share the resource; the arbiter grants it to one at a time.
- The grant is held as a 3-bit index and decoded to a one-hot 8-bit grant, the same index-to-line mapping as the team's 3-to-8 decoder.
- Sits between requester logic and the shared datapath. It owns grant, hold and release sequencing.

Parameters:
- MAX_HOLD, default 16: maximum cycles a grant may be held. 0 disables the timeout.
- CW, default 5: hold counter width. Must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request lines. req[k] is requester k.
- done  input  1  current owner releases the resource this cycle.
- gnt  output  8  one-hot grant, registered. gnt[k]=1 means k owns the resource.
- gnt_idx  output  3  binary index of the owner. Valid only when gnt_valid=1.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low. The polarity and synchronicity are fixed.
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, hold counter=0, state=IDLE, priority pointer ptr=3'd7. With ptr=7, requester 0 has first priority after reset.
- Reset mid-grant: everything returns to reset values immediately (asynchronously). No release pulse is produced.
- Winner selection (combinational): search req[(ptr+1)%8], req[(ptr+2)%8], …, req[ptr], wrapping. The first set bit wins.
- States:
  - IDLE: gnt_valid=0. If req!=0 at a clock edge, enter GRANT. At that edge gnt_idx=winner, gnt=1<<winner, gnt_valid=1, counter=1. Latency from req sampled to gnt visible is 1 cycle.
  - GRANT: gnt is stable. Each cycle the release condition is evaluated: rel = done | ~req[gnt_idx] | (MAX_HOLD!=0 && counter==MAX_HOLD).
    - If rel=0: counter increments, saturating at 2^CW-1.
    - If rel=1: ptr<=gnt_idx at the edge.
- Back-to-back grants, on release: a winner is computed using the updated pointer (the old gnt_idx) over the req value in the release cycle.
  - If any req is set: stay in GRANT with the new winner, counter=1. gnt switches directly with no idle cycle.
  - Else: enter IDLE with gnt=0, gnt_valid=0.
  - The released requester is lowest priority, but is re-granted if it is the only one still requesting.
- timeout: asserted for exactly the cycle after a release where only the MAX_HOLD term was true. If done=1 in the same cycle the limit is reached, done takes precedence and timeout stays 0.
- Request dropped: if req[gnt_idx] falls without done, that is treated as a release (no timeout).
- Invariants:
  - gnt is zero or one-hot at all times.
  - gnt==(gnt_valid ? 1<<gnt_idx : 0).
  - Requests that appear mid-grant never preempt the current owner.
- done while in IDLE is ignored.

Test Plan:
- Reset, then req=8'h01 → one cycle later gnt=8'h01, gnt_idx=0, gnt_valid=1. Then done=1 for one cycle → next cycle gnt=8'h00, gnt_valid=0.
- req=8'hFF held, done pulsed every 3rd cycle → grant order 0,1,2,…,7,0 with no idle cycle between grants. gnt is always one-hot.
- req=8'h24 with ptr=2 (requester 2 just released) → requester 5 granted (gnt=8'h20). After it releases, requester 2 is granted (gnt=8'h04).
- MAX_HOLD=4, req=8'h08 held, done=0 → gnt=8'h08 for 4 cycles, then timeout pulses once. Requester 3 is re-granted with counter=1 because it is the sole requester.
- MAX_HOLD=4 with done=1 in the same cycle the counter reaches 4 → release with timeout=0.
- rst_n driven low asynchronously mid-grant (gnt=8'h10) → gnt=0, gnt_valid=0 without waiting for a clock edge. After rst_n rises with req=8'h10, requester 4 is granted within 1 cycle.

Source files
------------

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant, per-grant hold limit
// and back-to-back handover without an idle cycle.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CW       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  // state   | meaning
  // S_IDLE  | no owner, waiting for any request
  // S_GRANT | r_idx owns the resource, hold counter running
  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_SAT = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_ptr, w_ptr_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic          r_valid, w_valid_nxt;
  logic [7:0]    r_gnt, w_gnt_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic [2:0]    w_base;
  logic [2:0]    w_j;
  logic [2:0]    w_off;
  logic [2:0]    w_winner;
  logic          w_any;
  logic          w_own_req;
  logic          w_hit;
  logic          w_rel;

  // On release the search starts after the outgoing owner, i.e. the updated pointer.
  assign w_base    = (r_state == S_GRANT) ? r_idx : r_ptr;
  assign w_any     = |req;
  assign w_own_req = req[r_idx];
  assign w_hit     = (MAX_HOLD != 0) && (r_cnt == CNT_MAX);
  assign w_rel     = done | ~w_own_req | w_hit;

  always_comb begin
    w_off = 3'd0;
    w_j   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      w_j = w_base + 3'd1 + k[2:0];
      if (req[w_j]) w_off = k[2:0];
    end
    w_winner = w_base + 3'd1 + w_off;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
    w_valid_nxt   = r_valid;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_idx_nxt   = w_winner;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_GRANT: begin
        if (w_rel) begin
          w_ptr_nxt     = r_idx;
          w_timeout_nxt = w_hit & ~done & w_own_req;
          if (w_any) begin
            w_idx_nxt = w_winner;
            w_cnt_nxt = CNT_ONE;
          end else begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = '0;
          end
        end else if (r_cnt != CNT_SAT) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_gnt_nxt = w_valid_nxt ? (8'b1 << w_idx_nxt) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 3'd7;
      r_idx     <= 3'd0;
      r_valid   <= 1'b0;
      r_gnt     <= 8'h00;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_idx     <= w_idx_nxt;
      r_valid   <= w_valid_nxt;
      r_gnt     <= w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: owner/pointer model checked every cycle plus directed
// scenarios with literal expectations.
module tb_rr_arbiter8;
  localparam int MH = 4;
  localparam int CWB = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  rr_arbiter8 #(.MAX_HOLD(MH), .CW(CWB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model: owner (-1 = none), cycles held, last released owner, timeout flag.
  int m_own = -1;
  int m_cnt = 0;
  int m_ptr = 7;
  bit m_to  = 1'b0;

  function automatic int pick(logic [7:0] r, int p);
    for (int k = 1; k <= 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1; m_cnt = 0; m_ptr = 7; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_own < 0) begin
        if (req != 8'h00) begin m_own = pick(req, m_ptr); m_cnt = 1; end
      end else begin
        bit hit, rel;
        hit = (MH != 0) && (m_cnt == MH);
        rel = done || !req[m_own] || hit;
        if (rel) begin
          m_to  = hit && !done && req[m_own];
          m_ptr = m_own;
          if (req != 8'h00) begin m_own = pick(req, m_ptr); m_cnt = 1; end
          else begin m_own = -1; m_cnt = 0; end
        end else if (m_cnt < (1 << CWB) - 1) begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] eg;
    eg = (m_own < 0) ? 8'h00 : 8'(1 << m_own);
    chk("model_gnt", {24'd0, gnt}, {24'd0, eg});
    chk("model_valid", {31'd0, gnt_valid}, {31'd0, (m_own >= 0)});
    if (m_own >= 0) chk("model_idx", {29'd0, gnt_idx}, m_own);
    chk("model_timeout", {31'd0, timeout}, {31'd0, m_to});
    chk("onehot", {31'd0, $onehot0(gnt)}, 32'd1);
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 8'h00; done = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    // single request, grant then release
    do_reset();
    chk("rst_gnt", {24'd0, gnt}, 32'h00);
    chk("rst_valid", {31'd0, gnt_valid}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    req = 8'h01; step();
    chk("t1_gnt", {24'd0, gnt}, 32'h01);
    chk("t1_idx", {29'd0, gnt_idx}, 32'd0);
    chk("t1_valid", {31'd0, gnt_valid}, 32'd1);
    req = 8'h00; done = 1'b1; step(); done = 1'b0;
    chk("t1_rel_gnt", {24'd0, gnt}, 32'h00);
    chk("t1_rel_valid", {31'd0, gnt_valid}, 32'd0);

    // all requesting, done every 3rd cycle: 0..7,0 with no gap
    do_reset();
    req = 8'hFF; step();
    for (int g = 0; g <= 8; g++) begin
      chk("rr_order", {24'd0, gnt}, 32'(1 << (g % 8)));
      step(2);
      chk("rr_hold", {24'd0, gnt}, 32'(1 << (g % 8)));
      done = 1'b1; step(); done = 1'b0;
    end
    req = 8'h00; done = 1'b1; step(); done = 1'b0;

    // pointer at 2 with req=24 -> 5, then 2
    do_reset();
    req = 8'h04; step();
    chk("p2_first", {24'd0, gnt}, 32'h04);
    req = 8'h24; done = 1'b1; step(); done = 1'b0;
    chk("p2_to5", {24'd0, gnt}, 32'h20);
    done = 1'b1; step(); done = 1'b0;
    chk("p5_to2", {24'd0, gnt}, 32'h04);
    req = 8'h00; done = 1'b1; step(); done = 1'b0;

    // hold limit with sole requester
    do_reset();
    req = 8'h08; step();
    for (int c = 1; c <= MH; c++) begin
      chk("hold_gnt", {24'd0, gnt}, 32'h08);
      chk("hold_no_to", {31'd0, timeout}, 32'd0);
      if (c < MH) step();
    end
    step();
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    chk("to_regrant", {24'd0, gnt}, 32'h08);
    step();
    chk("to_once", {31'd0, timeout}, 32'd0);
    // done on the cycle the limit is reached suppresses timeout
    step(2);
    done = 1'b1; step(); done = 1'b0;
    chk("done_wins_to", {31'd0, timeout}, 32'd0);
    chk("done_wins_gnt", {24'd0, gnt}, 32'h08);
    step();
    chk("done_wins_to2", {31'd0, timeout}, 32'd0);

    // owner drops its request: release, no timeout
    do_reset();
    req = 8'h03; step();
    chk("drop_first", {24'd0, gnt}, 32'h01);
    req = 8'h02; step();
    chk("drop_next", {24'd0, gnt}, 32'h02);
    chk("drop_no_to", {31'd0, timeout}, 32'd0);

    // asynchronous reset mid-grant
    do_reset();
    req = 8'h10; step();
    chk("ar_before", {24'd0, gnt}, 32'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_gnt", {24'd0, gnt}, 32'h00);
    chk("ar_valid", {31'd0, gnt_valid}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    step();
    chk("ar_regrant", {24'd0, gnt}, 32'h10);
    chk("ar_idx", {29'd0, gnt_idx}, 32'd4);
    req = 8'h00; step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
